lock_entry_ctrl: RTL and testbench

LOCK_ENTRY_CTRL -- requirements
Module: lock_entry_ctrl

---
 rtl/lock_pkg.sv | 22 ++
 rtl/lock_entry_ctrl_rise_det.sv | 19 +
 rtl/lock_entry_ctrl.sv | 129 ++++++++++++
 tb/tb_lock_entry_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock controller: FSM states, digit geometry
// and the default failed-attempt limit.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCK,
    ST_ALARM
  } lock_state_e;

  localparam int unsigned NUM_DIGITS       = 4;
  localparam int unsigned BCD_W            = 4;
  localparam int unsigned KEY_VALID_BIT    = 4;
  localparam int unsigned MAX_ATTEMPTS_DEF = 3;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= BCD_W'(9);
  endfunction

endpackage

// File: rtl/lock_entry_ctrl_rise_det.sv
// Registered rising-edge detector. The previous-value register resets high so
// a level already asserted when reset releases is not taken as a press.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/lock_entry_ctrl.sv
// Keypad entry controller: collects four BCD digits, requests an external
// comparison on enter, then opens the lock or escalates to alarm.
module lock_entry_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS  = MAX_ATTEMPTS_DEF,
  parameter int unsigned UNLOCK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  key_code,
  input  logic        enter,
  input  logic        clear,
  input  logic        alarm_clr,
  input  logic        match,
  output logic [15:0] entry_word,
  output logic [2:0]  digit_count,
  output logic        check,
  output logic        unlocked,
  output logic        alarm,
  output logic [1:0]  attempts
);

  localparam logic [1:0]  MAX_ATT     = 2'(MAX_ATTEMPTS);
  localparam logic [2:0]  FULL_COUNT  = 3'(NUM_DIGITS);
  localparam logic [15:0] UNLOCK_LOAD = 16'(UNLOCK_CYCLES - 1);

  lock_state_e       state_q;
  logic [15:0]       word_q;
  logic [2:0]        count_q;
  logic [1:0]        attempts_q;
  logic [1:0]        attempts_inc;
  logic [15:0]       timer_q;
  logic              check_q;
  logic              unlocked_q;
  logic              alarm_q;
  logic              digit_p;
  logic              enter_p;
  logic              clear_p;
  logic [BCD_W-1:0]  digit;

  assign digit = key_code[BCD_W-1:0];

  rise_det u_det_digit (.clk(clk), .rst(rst), .d_i(key_code[KEY_VALID_BIT]), .rise_o(digit_p));
  rise_det u_det_enter (.clk(clk), .rst(rst), .d_i(enter),                   .rise_o(enter_p));
  rise_det u_det_clear (.clk(clk), .rst(rst), .d_i(clear),                   .rise_o(clear_p));

  always_comb begin
    attempts_inc = (attempts_q >= MAX_ATT) ? MAX_ATT : attempts_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      count_q    <= '0;
      attempts_q <= '0;
      timer_q    <= '0;
      check_q    <= 1'b0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      check_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ENTRY: begin
          // A press of a higher-priority key swallows any lower-priority press
          // arriving in the same cycle, even when it has no effect itself.
          if (clear_p) begin
            word_q  <= '0;
            count_q <= '0;
            state_q <= ST_IDLE;
          end else if (enter_p) begin
            if (count_q == FULL_COUNT) begin
              state_q <= ST_CHECK;
              check_q <= 1'b1;
            end
          end else if (digit_p && is_bcd(digit) && (count_q < FULL_COUNT)) begin
            word_q  <= {word_q[11:0], digit};
            count_q <= count_q + 3'd1;
            state_q <= ST_ENTRY;
          end
        end
        ST_CHECK: begin
          word_q  <= '0;
          count_q <= '0;
          if (match) begin
            attempts_q <= '0;
            unlocked_q <= 1'b1;
            timer_q    <= UNLOCK_LOAD;
            state_q    <= ST_UNLOCK;
          end else begin
            attempts_q <= attempts_inc;
            if (attempts_inc == MAX_ATT) begin
              alarm_q <= 1'b1;
              state_q <= ST_ALARM;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_UNLOCK: begin
          if (clear_p || (timer_q == '0)) begin
            unlocked_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= ST_IDLE;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        ST_ALARM: begin
          if (alarm_clr) begin
            alarm_q    <= 1'b0;
            attempts_q <= '0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign entry_word  = word_q;
  assign digit_count = count_q;
  assign check       = check_q;
  assign unlocked    = unlocked_q;
  assign alarm       = alarm_q;
  assign attempts    = attempts_q;

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Directed bench for lock_entry_ctrl: a per-cycle vector table for digit entry
// and priority cases, then hand-written unlock, alarm and reset sequences.
module tb_lock_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  key_code = '0;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic        alarm_clr = 1'b0;
  logic        match = 1'b0;
  logic [15:0] entry_word;
  logic [2:0]  digit_count;
  logic        check;
  logic        unlocked;
  logic        alarm;
  logic [1:0]  attempts;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0]  key;
    logic        ent;
    logic        clr;
    logic [15:0] word;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[20];

  lock_entry_ctrl #(.MAX_ATTEMPTS(3), .UNLOCK_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .enter(enter), .clear(clear),
    .alarm_clr(alarm_clr), .match(match), .entry_word(entry_word),
    .digit_count(digit_count), .check(check), .unlocked(unlocked),
    .alarm(alarm), .attempts(attempts)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    key_code = {1'b1, d};
    step();
    key_code = '0;
    step();
  endtask

  task automatic enter_code(input logic [15:0] code, input logic m, input string nm);
    press(code[15:12]);
    press(code[11:8]);
    press(code[7:4]);
    press(code[3:0]);
    chk({nm, "_word"}, 32'(entry_word), 32'(code));
    match = m;
    enter = 1'b1;
    step();
    chk({nm, "_check_hi"}, 32'(check), 32'd1);
    enter = 1'b0;
    step();
    chk({nm, "_check_lo"}, 32'(check), 32'd0);
    chk({nm, "_cleared"}, 32'(entry_word), 32'd0);
  endtask

  task automatic set_row(input int i, input logic [4:0] k, input logic e, input logic c,
                         input logic [15:0] w, input logic [2:0] n);
    tbl[i].key  = k;
    tbl[i].ent  = e;
    tbl[i].clr  = c;
    tbl[i].word = w;
    tbl[i].cnt  = n;
  endtask

  initial begin
    int n;
    int chk_seen;

    set_row(0,  5'h15, 1'b0, 1'b0, 16'h0005, 3'd1);
    set_row(1,  5'h00, 1'b0, 1'b0, 16'h0005, 3'd1);
    set_row(2,  5'h16, 1'b0, 1'b0, 16'h0056, 3'd2);
    set_row(3,  5'h00, 1'b1, 1'b0, 16'h0056, 3'd2);
    set_row(4,  5'h00, 1'b0, 1'b0, 16'h0056, 3'd2);
    set_row(5,  5'h17, 1'b0, 1'b0, 16'h0567, 3'd3);
    set_row(6,  5'h00, 1'b0, 1'b0, 16'h0567, 3'd3);
    set_row(7,  5'h18, 1'b0, 1'b0, 16'h5678, 3'd4);
    set_row(8,  5'h00, 1'b0, 1'b0, 16'h5678, 3'd4);
    set_row(9,  5'h19, 1'b0, 1'b0, 16'h5678, 3'd4);
    set_row(10, 5'h00, 1'b0, 1'b0, 16'h5678, 3'd4);
    set_row(11, 5'h13, 1'b1, 1'b1, 16'h0000, 3'd0);
    set_row(12, 5'h00, 1'b0, 1'b0, 16'h0000, 3'd0);
    set_row(13, 5'h1A, 1'b0, 1'b0, 16'h0000, 3'd0);
    set_row(14, 5'h00, 1'b0, 1'b0, 16'h0000, 3'd0);
    set_row(15, 5'h12, 1'b0, 1'b0, 16'h0002, 3'd1);
    set_row(16, 5'h12, 1'b0, 1'b0, 16'h0002, 3'd1);
    set_row(17, 5'h00, 1'b0, 1'b0, 16'h0002, 3'd1);
    set_row(18, 5'h00, 1'b0, 1'b1, 16'h0000, 3'd0);
    set_row(19, 5'h00, 1'b0, 1'b0, 16'h0000, 3'd0);

    step();
    step();
    chk("rst_word", 32'(entry_word), 32'd0);
    chk("rst_count", 32'(digit_count), 32'd0);
    chk("rst_check", 32'(check), 32'd0);
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_attempts", 32'(attempts), 32'd0);
    rst = 1'b1;
    step();
    step();

    for (int i = 0; i < 20; i++) begin
      key_code = tbl[i].key;
      enter    = tbl[i].ent;
      clear    = tbl[i].clr;
      step();
      chk($sformatf("row%0d_word", i), 32'(entry_word), 32'(tbl[i].word));
      chk($sformatf("row%0d_count", i), 32'(digit_count), 32'(tbl[i].cnt));
      chk($sformatf("row%0d_check", i), 32'(check), 32'd0);
      chk($sformatf("row%0d_unlocked", i), 32'(unlocked), 32'd0);
    end

    // Full unlock: count the open window, with digits and enter pressed inside it.
    enter_code(16'h1234, 1'b1, "unlock");
    chk("unlock_attempts", 32'(attempts), 32'd0);
    n = 0;
    chk_seen = 0;
    while (unlocked && n < 2000) begin
      n++;
      key_code = (n == 10) ? 5'h17 : 5'h00;
      enter    = (n == 20);
      step();
      if (check) chk_seen++;
    end
    chk("unlock_cycles", 32'(n), 32'd1000);
    chk("unlock_no_check", 32'(chk_seen), 32'd0);
    chk("unlock_count", 32'(digit_count), 32'd0);
    press(4'd5);
    chk("after_unlock_idle", 32'(digit_count), 32'd1);
    clear = 1'b1; step(); clear = 1'b0; step();

    // Early relock by clear.
    enter_code(16'h9876, 1'b1, "relock");
    chk("relock_open", 32'(unlocked), 32'd1);
    step(); step(); step();
    clear = 1'b1;
    step();
    chk("relock_closed", 32'(unlocked), 32'd0);
    clear = 1'b0;
    step();
    chk("relock_stays", 32'(unlocked), 32'd0);

    // Three consecutive failures raise the alarm.
    enter_code(16'h1111, 1'b0, "fail1");
    chk("fail1_attempts", 32'(attempts), 32'd1);
    chk("fail1_alarm", 32'(alarm), 32'd0);
    enter_code(16'h2222, 1'b0, "fail2");
    chk("fail2_attempts", 32'(attempts), 32'd2);
    enter_code(16'h3333, 1'b0, "fail3");
    chk("fail3_alarm", 32'(alarm), 32'd1);
    chk("fail3_attempts", 32'(attempts), 32'd3);
    press(4'd2);
    clear = 1'b1; step(); clear = 1'b0; step();
    chk("alarm_digit_ignored", 32'(digit_count), 32'd0);
    chk("alarm_clear_ignored", 32'(alarm), 32'd1);
    alarm_clr = 1'b1;
    step();
    chk("alarm_clr_alarm", 32'(alarm), 32'd0);
    chk("alarm_clr_attempts", 32'(attempts), 32'd0);
    alarm_clr = 1'b0;
    step();

    // Held valid line registers a single digit.
    key_code = 5'h14;
    for (int i = 0; i < 50; i++) step();
    key_code = '0;
    step();
    chk("hold_count", 32'(digit_count), 32'd1);
    chk("hold_word", 32'(entry_word), 32'h0004);
    clear = 1'b1; step(); clear = 1'b0; step();

    // A success wipes the failure count.
    enter_code(16'h0101, 1'b0, "fail_once");
    chk("fail_once_attempts", 32'(attempts), 32'd1);
    enter_code(16'h0202, 1'b1, "success");
    chk("success_attempts", 32'(attempts), 32'd0);
    clear = 1'b1; step(); clear = 1'b0; step();

    // Asynchronous reset in UNLOCK with enter held through release.
    enter_code(16'h4321, 1'b1, "rst_unlock");
    enter = 1'b1;
    step(); step();
    chk("pre_rst_open", 32'(unlocked), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("async_unlocked", 32'(unlocked), 32'd0);
    chk("async_alarm", 32'(alarm), 32'd0);
    chk("async_check", 32'(check), 32'd0);
    chk("async_word", 32'(entry_word), 32'd0);
    chk("async_attempts", 32'(attempts), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("held_enter_count", 32'(digit_count), 32'd4);
    step();
    chk("held_enter_no_check", 32'(check), 32'd0);
    enter = 1'b0;
    step();
    chk("enter_low_no_check", 32'(check), 32'd0);
    enter = 1'b1;
    step();
    chk("enter_repress_check", 32'(check), 32'd1);
    enter = 1'b0;
    step();
    chk("enter_repress_open", 32'(unlocked), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
